// File: rtl/enc_16x4_chk.sv
// Registered 16-to-4 priority encoder with one-hot validity checking and a saturating
// fault counter. Valid/ready handshake on input and output sides.
module enc_16x4_chk #(
    parameter bit          PRIO_MSB = 1'b1,
    parameter int unsigned FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       D,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              X,
    output logic              Y,
    output logic              Z,
    output logic              W,
    output logic              zero_err,
    output logic              multi_err,
    output logic [FCNT_W-1:0] fault_cnt
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e              state_q;
    logic [3:0]          idx_q;
    logic [3:0]          idx_d;
    logic                zero_q;
    logic                multi_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                zero_d;
    logic                multi_d;
    logic                fault_d;
    logic                accept;
    logic                xfer;

    // Later iterations overwrite earlier ones, so the scan order sets the priority.
    always_comb begin
        idx_d = 4'd0;
        if (PRIO_MSB) begin
            for (int i = 0; i < 16; i++) begin
                if (D[i]) idx_d = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (D[i]) idx_d = 4'(i);
            end
        end
    end

    always_comb begin
        zero_d  = (D == 16'd0);
        // Clearing the lowest set bit leaves something only if two or more bits were set.
        multi_d = |(D & (D - 16'd1));
        fault_d = zero_d | multi_d;
    end

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            idx_q   <= 4'd0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            unique case (state_q)
                StEmpty: if (accept) state_q <= StFull;
                StFull:  if (xfer && !accept) state_q <= StEmpty;
            endcase
            if (accept) begin
                idx_q   <= idx_d;
                zero_q  <= zero_d;
                multi_q <= multi_d;
            end
            if (accept && fault_d && (fcnt_q != '1)) begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign {W, Z, Y, X} = idx_q;
    assign zero_err     = zero_q;
    assign multi_err    = multi_q;
    assign fault_cnt    = fcnt_q;

endmodule

// File: tb/tb_enc_16x4_chk.sv
// Self-checking bench for enc_16x4_chk: MSB-priority, LSB-priority and 2-bit-counter
// instances share stimulus; a scoreboard queue tracks accepted samples.
module tb_enc_16x4_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] D = 16'd0;

    logic       in_ready, out_valid, X, Y, Z, W, zero_err, multi_err;
    logic [7:0] fault_cnt;
    logic       in_ready_l, out_valid_l, X_l, Y_l, Z_l, W_l, zero_err_l, multi_err_l;
    logic [7:0] fault_cnt_l;
    logic       in_ready_s, out_valid_s, X_s, Y_s, Z_s, W_s, zero_err_s, multi_err_s;
    logic [1:0] fault_cnt_s;

    enc_16x4_chk #(.PRIO_MSB(1'b1), .FCNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .X(X), .Y(Y), .Z(Z), .W(W),
        .zero_err(zero_err), .multi_err(multi_err), .fault_cnt(fault_cnt)
    );

    enc_16x4_chk #(.PRIO_MSB(1'b0), .FCNT_W(8)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .D(D),
        .out_valid(out_valid_l), .out_ready(out_ready), .X(X_l), .Y(Y_l), .Z(Z_l), .W(W_l),
        .zero_err(zero_err_l), .multi_err(multi_err_l), .fault_cnt(fault_cnt_l)
    );

    enc_16x4_chk #(.PRIO_MSB(1'b1), .FCNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .D(D),
        .out_valid(out_valid_s), .out_ready(out_ready), .X(X_s), .Y(Y_s), .Z(Z_s), .W(W_s),
        .zero_err(zero_err_s), .multi_err(multi_err_s), .fault_cnt(fault_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx_m;
        logic [3:0] idx_l;
        logic       zero;
        logic       multi;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   push_cnt = 0;
    int   xfer_cnt = 0;

    function automatic logic [3:0] ref_idx(input logic [15:0] d, input bit msb);
        for (int i = 0; i < 16; i++) begin
            int b;
            b = msb ? 15 - i : i;
            if (d[b]) return 4'(b);
        end
        return 4'd0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Scoreboard: sample handshakes mid-cycle; they take effect on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: transfer with no expected sample");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    xfer_cnt++;
                    checks++;
                    if ({W, Z, Y, X} !== e.idx_m) begin
                        errors++;
                        $display("FAIL sb_idx_msb: got %0h want %0h", {W, Z, Y, X}, e.idx_m);
                    end
                    checks++;
                    if ({W_l, Z_l, Y_l, X_l} !== e.idx_l) begin
                        errors++;
                        $display("FAIL sb_idx_lsb: got %0h want %0h",
                                 {W_l, Z_l, Y_l, X_l}, e.idx_l);
                    end
                    checks++;
                    if ({zero_err, multi_err, zero_err_l, multi_err_l} !==
                        {e.zero, e.multi, e.zero, e.multi}) begin
                        errors++;
                        $display("FAIL sb_flags: got %b%b/%b%b want %b%b", zero_err, multi_err,
                                 zero_err_l, multi_err_l, e.zero, e.multi);
                    end
                    checks++;
                    if (out_valid_l !== 1'b1 || out_valid_s !== 1'b1) begin
                        errors++;
                        $display("FAIL sb_valid_peers: got %b%b want 11", out_valid_l,
                                 out_valid_s);
                    end
                    checks++;
                    if (fault_cnt !== 8'(sat(model_cnt, 255)) ||
                        fault_cnt_l !== 8'(sat(model_cnt, 255)) ||
                        fault_cnt_s !== 2'(sat(model_cnt, 3))) begin
                        errors++;
                        $display("FAIL sb_fault_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                                 fault_cnt, fault_cnt_l, fault_cnt_s, sat(model_cnt, 255),
                                 sat(model_cnt, 255), sat(model_cnt, 3));
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.idx_m = ref_idx(D, 1'b1);
                e.idx_l = ref_idx(D, 1'b0);
                e.zero  = (D == 16'd0);
                e.multi = ($countones(D) >= 2);
                sb.push_back(e);
                push_cnt++;
                if (e.zero || e.multi) model_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output bit ok);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [15:0] rand_d();
        int unsigned a, b, k;
        k = $urandom_range(0, 3);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        if (k == 0) return 16'd0;
        if (k == 1) return (16'd1 << a) | (16'd1 << b);
        return 16'd1 << a;
    endfunction

    task automatic test_reset();
        tick();
        checks++;
        if ({out_valid, W, Z, Y, X, zero_err, multi_err} !== 7'd0 || fault_cnt !== 8'd0 ||
            fault_cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b idx=%0h z=%b m=%b cnt=%0d want all 0",
                     out_valid, {W, Z, Y, X}, zero_err, multi_err, fault_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_walk();
        bit ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            D = 16'd1 << i;
            tick();
            checks++;
            if (out_valid !== 1'b1 || {W, Z, Y, X} !== 4'(i) || zero_err || multi_err) begin
                errors++;
                $display("FAIL walk_%0d: got v=%b idx=%0h z=%b m=%b want 1 %0h 0 0", i,
                         out_valid, {W, Z, Y, X}, zero_err, multi_err, i);
            end
        end
        drain(ok);
        checks++;
        if (!ok || fault_cnt !== 8'd0) begin
            errors++;
            $display("FAIL walk_end: got drained=%b cnt=%0d want 1 0", ok, fault_cnt);
        end
    endtask

    task automatic test_multi();
        bit ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        D = 16'h8001;
        tick();
        checks++;
        if ({W, Z, Y, X} !== 4'hF || multi_err !== 1'b1 || zero_err !== 1'b0) begin
            errors++;
            $display("FAIL multi_msb: got idx=%0h m=%b z=%b want f 1 0", {W, Z, Y, X},
                     multi_err, zero_err);
        end
        checks++;
        if ({W_l, Z_l, Y_l, X_l} !== 4'h0 || multi_err_l !== 1'b1) begin
            errors++;
            $display("FAIL multi_lsb: got idx=%0h m=%b want 0 1", {W_l, Z_l, Y_l, X_l},
                     multi_err_l);
        end
        drain(ok);
        checks++;
        if (!ok || fault_cnt !== 8'd1 || fault_cnt_l !== 8'd1) begin
            errors++;
            $display("FAIL multi_cnt: got drained=%b cnt=%0d/%0d want 1 1/1", ok, fault_cnt,
                     fault_cnt_l);
        end
    endtask

    task automatic test_zero();
        bit ok;
        in_valid = 1'b1;
        D = 16'h0000;
        tick();
        checks++;
        if ({W, Z, Y, X} !== 4'h0 || zero_err !== 1'b1 || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_flags: got idx=%0h z=%b m=%b want 0 1 0", {W, Z, Y, X},
                     zero_err, multi_err);
        end
        drain(ok);
        checks++;
        if (!ok || fault_cnt !== 8'd2) begin
            errors++;
            $display("FAIL zero_cnt: got drained=%b cnt=%0d want 1 2", ok, fault_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] v [6];
        int k, p0, x0;
        bit ok;
        v[0] = 16'h0040; v[1] = 16'h0100; v[2] = 16'h0002;
        v[3] = 16'h8000; v[4] = 16'h0010; v[5] = 16'h0001;
        p0 = push_cnt;
        x0 = xfer_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        D = v[0];
        tick();
        for (int s = 0; s < 5; s++) begin
            D = s[0] ? 16'hFFFF : 16'h0000;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_%0d: got %b want 0", s, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || {W, Z, Y, X} !== 4'd6 || zero_err || multi_err) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b idx=%0h z=%b m=%b want 1 6 0 0", s,
                         out_valid, {W, Z, Y, X}, zero_err, multi_err);
            end
        end
        checks++;
        if (fault_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_no_count: got %0d want 2", fault_cnt);
        end
        out_ready = 1'b1;
        k = 1;
        for (int c = 0; c < 20 && k < 6; c++) begin
            bit acc;
            D = v[k];
            #1;
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        drain(ok);
        checks++;
        if (!ok || push_cnt - p0 != 6 || xfer_cnt - x0 != 6) begin
            errors++;
            $display("FAIL bp_order: got drained=%b pushed=%0d moved=%0d want 1 6 6", ok,
                     push_cnt - p0, xfer_cnt - x0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            D = rand_d();
            #1;
            checks++;
            if (in_ready !== 1'b1 || in_ready_l !== 1'b1 || in_ready_s !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got %b%b%b want 111", i, in_ready, in_ready_l,
                         in_ready_s);
            end
            tick();
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_drain: got 0 want 1");
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            D = rand_d();
            tick();
        end
        drain(ok);
        checks++;
        if (!ok || fault_cnt !== 8'(sat(model_cnt, 255)) ||
            fault_cnt_s !== 2'(sat(model_cnt, 3))) begin
            errors++;
            $display("FAIL rand_end: got drained=%b cnt=%0d/%0d want 1 %0d/%0d", ok,
                     fault_cnt, fault_cnt_s, sat(model_cnt, 255), sat(model_cnt, 3));
        end
    endtask

    task automatic test_reset_midflight();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        D = 16'h0000;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        sb.delete();
        model_cnt = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_valid_l !== 1'b0 || out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid: got %b%b%b want 000", out_valid, out_valid_l,
                     out_valid_s);
        end
        checks++;
        if (fault_cnt !== 8'd0 || fault_cnt_l !== 8'd0 || fault_cnt_s !== 2'd0 ||
            {W, Z, Y, X, zero_err, multi_err} !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid_state: got cnt=%0d/%0d/%0d idx=%0h z=%b want 0", fault_cnt,
                     fault_cnt_l, fault_cnt_s, {W, Z, Y, X}, zero_err);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            D = i[0] ? 16'h0003 : 16'h0000;
            tick();
        end
        drain(ok);
        checks++;
        if (!ok || fault_cnt_s !== 2'd3 || fault_cnt !== 8'd5) begin
            errors++;
            $display("FAIL sat_reach: got drained=%b cnt=%0d/%0d want 1 3/5", ok, fault_cnt_s,
                     fault_cnt);
        end
        in_valid = 1'b1;
        D = 16'hA000;
        tick();
        D = 16'h0000;
        tick();
        drain(ok);
        checks++;
        if (!ok || fault_cnt_s !== 2'd3 || fault_cnt !== 8'd7) begin
            errors++;
            $display("FAIL sat_hold: got drained=%b cnt=%0d/%0d want 1 3/7", ok, fault_cnt_s,
                     fault_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_multi();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
